zero_word_compressor: RTL and testbench

//  - Compression front-end stage that sits directly upstream of the Aligner.
//  - Takes raw 256-bit blocks, split into 16 x 16-bit words.
//  - Emits the {cpr_data_out, tag_out, len_out} record that is pushed into the aligner input FIFO.
//  - Zero words are suppressed: tag bit i = 1 when word i is nonzero.
//  - Nonzero words are packed toward the LSB.
//  - len is the record length in bytes: 2 (tag) + 2 per nonzero word.

---
 rtl/zero_word_compressor.sv | 137 +++++++++++++
 tb/tb_zero_word_compressor.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/zero_word_compressor.sv
// Zero-word compressor: drops all-zero 16-bit words from a 256-bit block, packs survivors LSB-first.
// Optional statistics counters are enabled by defining ZWC_STATS_EN.
module zero_word_compressor #(
    parameter int WORD_WIDTH = 16,
    parameter int NUM_WORDS  = 16,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                             clk,
    input  logic                             reset,
`ifdef ZWC_STATS_EN
    input  logic                             stat_clear,
    output logic [31:0]                      stat_blocks,
    output logic [31:0]                      stat_bytes,
`endif
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WORD_WIDTH*NUM_WORDS-1:0]  in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [WORD_WIDTH*NUM_WORDS-1:0]  cpr_data_out,
    output logic [NUM_WORDS-1:0]             tag_out,
    output logic [LEN_WIDTH-1:0]             len_out
);

    localparam int DATA_WIDTH = WORD_WIDTH * NUM_WORDS;
    localparam int POS_WIDTH  = $clog2(NUM_WORDS + 1);
    localparam int LEN6_WIDTH = POS_WIDTH + 1;

    logic [NUM_WORDS-1:0]  w_tag;
    logic [POS_WIDTH-1:0]  w_pos [NUM_WORDS];
    logic                  w_s2_adv;
    logic                  w_s1_take;
    logic [DATA_WIDTH-1:0] w_pack;
    logic [POS_WIDTH-1:0]  w_pop;
    logic [LEN6_WIDTH-1:0] w_len6;

    logic                  r_s1_valid;
    logic [DATA_WIDTH-1:0] r_s1_data;
    logic [NUM_WORDS-1:0]  r_s1_tag;
    logic [POS_WIDTH-1:0]  r_s1_pos [NUM_WORDS];

    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_cpr;
    logic [NUM_WORDS-1:0]  r_tag;
    logic [LEN_WIDTH-1:0]  r_len;

    assign w_s2_adv  = !r_out_valid || out_ready;
    assign in_ready  = !r_s1_valid || w_s2_adv;
    assign w_s1_take = in_valid && in_ready;

    // Tag and exclusive prefix popcount: pos[i] is the output slot of word i.
    always_comb begin : tag_pos
        logic [POS_WIDTH-1:0] acc;
        acc = '0;
        w_tag = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            w_tag[i] = |in_data[i*WORD_WIDTH +: WORD_WIDTH];
            w_pos[i] = acc;
            acc      = acc + POS_WIDTH'(w_tag[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_s1_valid <= 1'b0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (w_s1_take) begin
            r_s1_data <= in_data;
            r_s1_tag  <= w_tag;
            r_s1_pos  <= w_pos;
        end
    end

    // Word i can only land in a slot j <= i, so the inner loop starts at j.
    always_comb begin
        w_pack = '0;
        for (int j = 0; j < NUM_WORDS; j++) begin
            for (int i = j; i < NUM_WORDS; i++) begin
                if (r_s1_tag[i] && (r_s1_pos[i] == POS_WIDTH'(j))) begin
                    w_pack[j*WORD_WIDTH +: WORD_WIDTH] = w_pack[j*WORD_WIDTH +: WORD_WIDTH]
                                                       | r_s1_data[i*WORD_WIDTH +: WORD_WIDTH];
                end
            end
        end
    end

    assign w_pop  = r_s1_pos[NUM_WORDS-1] + POS_WIDTH'(r_s1_tag[NUM_WORDS-1]);
    assign w_len6 = {w_pop, 1'b0} + LEN6_WIDTH'(2);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_out_valid <= 1'b0;
            r_cpr       <= '0;
            r_tag       <= '0;
            r_len       <= '0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_cpr <= w_pack;
                r_tag <= r_s1_tag;
                r_len <= LEN_WIDTH'(w_len6);
            end
        end
    end

    assign out_valid    = r_out_valid;
    assign cpr_data_out = r_cpr;
    assign tag_out      = r_tag;
    assign len_out      = r_len;

`ifdef ZWC_STATS_EN
    logic        w_out_xfer;
    logic [31:0] r_stat_blocks;
    logic [31:0] r_stat_bytes;

    assign w_out_xfer = r_out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!reset || stat_clear) begin
            r_stat_blocks <= '0;
            r_stat_bytes  <= '0;
        end else if (w_out_xfer) begin
            r_stat_blocks <= r_stat_blocks + 32'd1;
            r_stat_bytes  <= r_stat_bytes + 32'(r_len);
        end
    end

    assign stat_blocks = r_stat_blocks;
    assign stat_bytes  = r_stat_bytes;
`endif

endmodule

// File: tb/tb_zero_word_compressor.sv
// Directed bench for zero_word_compressor: vector table plus stall and mid-flight reset sequences.
module tb_zero_word_compressor;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [255:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [255:0] cpr_data_out;
    logic [15:0]  tag_out;
    logic [7:0]   len_out;
`ifdef ZWC_STATS_EN
    logic         stat_clear = 1'b0;
    logic [31:0]  stat_blocks;
    logic [31:0]  stat_bytes;
`endif

    zero_word_compressor dut (
        .clk          (clk),
        .reset        (reset),
`ifdef ZWC_STATS_EN
        .stat_clear   (stat_clear),
        .stat_blocks  (stat_blocks),
        .stat_bytes   (stat_bytes),
`endif
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .cpr_data_out (cpr_data_out),
        .tag_out      (tag_out),
        .len_out      (len_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] data;
        logic [15:0]  tag;
        logic [7:0]   len;
        logic [255:0] cpr;
    } vec_t;

    vec_t vecs [7];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_check(input int v);
        int lat;
        in_data   = vecs[v].data;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check($sformatf("v%0d_in_ready", v), 256'(in_ready), 256'd1);
        step();
        in_valid = 1'b0;
        in_data  = '0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        check($sformatf("v%0d_latency", v), 256'(lat), 256'd2);
        check($sformatf("v%0d_tag", v), 256'(tag_out), 256'(vecs[v].tag));
        check($sformatf("v%0d_len", v), 256'(len_out), 256'(vecs[v].len));
        check($sformatf("v%0d_cpr", v), cpr_data_out, vecs[v].cpr);
        step();
        check($sformatf("v%0d_once", v), 256'(out_valid), 256'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    logic [255:0] sdata [8];
    logic [15:0]  stag  [8];
    logic [255:0] scpr  [8];

    initial begin
        int idx, oidx, extra, spurious;
        logic saw_stall, have_hold, acc, xfer;
        logic [255:0] h_cpr;
        logic [15:0]  h_tag;
        logic [7:0]   h_len;

        vecs[0].data = 256'h4321_FEDC_BA98_7654_321F_BCDE_A987_6543_21FE_DCBA_9876_5432_1FED_CBA9_8765_4321;
        vecs[0].tag  = 16'hFFFF;
        vecs[0].len  = 8'h22;
        vecs[0].cpr  = 256'h4321_FEDC_BA98_7654_321F_BCDE_A987_6543_21FE_DCBA_9876_5432_1FED_CBA9_8765_4321;
        vecs[1].data = '0;
        vecs[1].tag  = 16'h0000;
        vecs[1].len  = 8'h02;
        vecs[1].cpr  = '0;
        vecs[2].data = '0;
        vecs[2].data[15:0]  = 16'h4321;
        vecs[2].data[95:80] = 16'hBEEF;
        vecs[2].tag  = 16'h0021;
        vecs[2].len  = 8'h06;
        vecs[2].cpr  = 256'hBEEF_4321;
        vecs[3].data = {16'hA5A5, 240'b0};
        vecs[3].tag  = 16'h8000;
        vecs[3].len  = 8'h04;
        vecs[3].cpr  = 256'hA5A5;
        vecs[4].data = '0;
        vecs[4].data[31:16]   = 16'h0001;
        vecs[4].data[63:48]   = 16'h8000;
        vecs[4].data[239:224] = 16'h1234;
        vecs[4].tag  = 16'h400A;
        vecs[4].len  = 8'h08;
        vecs[4].cpr  = 256'h1234_8000_0001;
        vecs[5].data = 256'hFFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_8888_7777_6666_5555_4444_3333_2222_1111_0000;
        vecs[5].tag  = 16'hFFFE;
        vecs[5].len  = 8'h20;
        vecs[5].cpr  = 256'h0000_FFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_8888_7777_6666_5555_4444_3333_2222_1111;
        vecs[6].data = '0;
        vecs[6].data[127:112] = 16'h0100;
        vecs[6].tag  = 16'h0080;
        vecs[6].len  = 8'h04;
        vecs[6].cpr  = 256'h0100;

        // Stream block k: word k = A00k, word k+8 = B00k -> two packed words.
        for (int k = 0; k < 8; k++) begin
            sdata[k] = '0;
            sdata[k][k*16 +: 16]     = 16'hA000 + 16'(k);
            sdata[k][(k+8)*16 +: 16] = 16'hB000 + 16'(k);
            stag[k] = (16'd1 << k) | (16'd1 << (k + 8));
            scpr[k] = {224'b0, 16'hB000 + 16'(k), 16'hA000 + 16'(k)};
        end

        // Reset held three cycles.
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("rst%0d_out_valid", c), 256'(out_valid), 256'd0);
            check($sformatf("rst%0d_tag", c), 256'(tag_out), 256'd0);
            check($sformatf("rst%0d_len", c), 256'(len_out), 256'd0);
        end
        check("rst_cpr", cpr_data_out, 256'd0);
        reset = 1'b1;
        step();
        #1;
        check("post_rst_in_ready", 256'(in_ready), 256'd1);
        check("post_rst_out_valid", 256'(out_valid), 256'd0);

        for (int v = 0; v < 7; v++) send_check(v);

`ifdef ZWC_STATS_EN
        check("stat_blocks_vec", 256'(stat_blocks), 256'd7);
        check("stat_bytes_vec", 256'(stat_bytes), 256'd90);
`endif

        // Back-to-back stream with out_ready low in cycles 3..6.
        idx = 0; oidx = 0; extra = 0;
        saw_stall = 1'b0; have_hold = 1'b0;
        for (int c = 0; c < 30; c++) begin
            out_ready = !(c >= 3 && c <= 6);
            in_valid  = (idx < 8);
            in_data   = (idx < 8) ? sdata[idx] : '0;
            #1;
            acc  = in_valid && in_ready;
            xfer = out_valid && out_ready;
            if (!in_ready) saw_stall = 1'b1;
            if (have_hold) begin
                check($sformatf("hold%0d_valid", c), 256'(out_valid), 256'd1);
                check($sformatf("hold%0d_tag", c), 256'(tag_out), 256'(h_tag));
                check($sformatf("hold%0d_len", c), 256'(len_out), 256'(h_len));
                check($sformatf("hold%0d_cpr", c), cpr_data_out, h_cpr);
            end
            have_hold = out_valid && !out_ready;
            h_cpr = cpr_data_out;
            h_tag = tag_out;
            h_len = len_out;
            if (xfer) begin
                if (oidx < 8) begin
                    check($sformatf("s%0d_tag", oidx), 256'(tag_out), 256'(stag[oidx]));
                    check($sformatf("s%0d_len", oidx), 256'(len_out), 256'h06);
                    check($sformatf("s%0d_cpr", oidx), cpr_data_out, scpr[oidx]);
                end else begin
                    extra++;
                end
                oidx++;
            end
            if (acc) idx++;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_accepted", 256'(idx), 256'd8);
        check("stream_emitted", 256'(oidx), 256'd8);
        check("stream_extra", 256'(extra), 256'd0);
        check("stream_in_ready_dropped", 256'(saw_stall), 256'd1);

`ifdef ZWC_STATS_EN
        check("stat_blocks_stream", 256'(stat_blocks), 256'd15);
        check("stat_bytes_stream", 256'(stat_bytes), 256'd138);
`endif

        // Two records in flight, then a one-cycle reset.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = vecs[0].data;
        step();
        in_data   = vecs[4].data;
        step();
        in_valid  = 1'b0;
        in_data   = '0;
        check("inflight_out_valid", 256'(out_valid), 256'd1);
        reset = 1'b0;
        step();
        check("midrst_out_valid", 256'(out_valid), 256'd0);
        check("midrst_tag", 256'(tag_out), 256'd0);
        check("midrst_len", 256'(len_out), 256'd0);
`ifdef ZWC_STATS_EN
        check("stat_blocks_rst", 256'(stat_blocks), 256'd0);
        check("stat_bytes_rst", 256'(stat_bytes), 256'd0);
`endif
        reset = 1'b1;
        out_ready = 1'b1;
        spurious = 0;
        for (int c = 0; c < 6; c++) begin
            step();
            if (out_valid) spurious++;
        end
        check("midrst_no_stale", 256'(spurious), 256'd0);
        send_check(2);

`ifdef ZWC_STATS_EN
        check("stat_blocks_after", 256'(stat_blocks), 256'd1);
        check("stat_bytes_after", 256'(stat_bytes), 256'd6);
        stat_clear = 1'b1;
        step();
        stat_clear = 1'b0;
        check("stat_blocks_clear", 256'(stat_blocks), 256'd0);
        check("stat_bytes_clear", 256'(stat_bytes), 256'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
